// File: rtl/wptr_full_level.sv
// rtl/wptr_full_level.sv - async FIFO write pointer, full flag, occupancy level and overflow tracking
module wptr_full_level #(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic             wclk_i,
  input  logic             wrst_n_i,
  input  logic             winc_i,
  input  logic [ASIZE:0]   wq2_rptr_i,
  input  logic             wovf_clr_i,
  output logic [ASIZE-1:0] waddr_o,
  output logic [ASIZE:0]   wptr_o,
  output logic             wfull_o,
  output logic             walmost_full_o,
  output logic [ASIZE:0]   wlevel_o,
  output logic             woverflow_o
);

  localparam logic [ASIZE:0] AFULL_TH = AFULL_THRESH[ASIZE:0];

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] wlevel_q, wlevel_d;
  logic           wfull_q, wfull_d;
  logic           walmost_full_q, walmost_full_d;
  logic           woverflow_q, woverflow_d;
  logic [ASIZE:0] rbin_s;
  logic           wen;

  // Each binary bit of the read count is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr_i >> i);
    end
  end

  // Next-state values are computed from wbin_d so flags and level track the
  // committing write on the same edge.
  always_comb begin
    wen            = winc_i & ~wfull_q;
    wbin_d         = wbin_q + {{ASIZE{1'b0}}, wen};
    wptr_d         = (wbin_d >> 1) ^ wbin_d;
    wfull_d        = (wptr_d == {~wq2_rptr_i[ASIZE:ASIZE-1], wq2_rptr_i[ASIZE-2:0]});
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= AFULL_TH);
    woverflow_d    = (winc_i & wfull_q) | (woverflow_q & ~wovf_clr_i);
  end

  always_ff @(posedge wclk_i) begin
    if (!wrst_n_i) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr_o        = wbin_q[ASIZE-1:0];
  assign wptr_o         = wptr_q;
  assign wfull_o        = wfull_q;
  assign walmost_full_o = walmost_full_q;
  assign wlevel_o       = wlevel_q;
  assign woverflow_o    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// tb/tb_wptr_full_level.sv - directed bench for wptr_full_level with ASIZE=4, AFULL_THRESH=12
module tb_wptr_full_level;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_tests = 0;
  int n_fail  = 0;

  wptr_full_level #(.ASIZE(4), .AFULL_THRESH(12)) dut (
    .wclk_i         (wclk),
    .wrst_n_i       (wrst_n),
    .winc_i         (winc),
    .wq2_rptr_i     (wq2_rptr),
    .wovf_clr_i     (wovf_clr),
    .waddr_o        (waddr),
    .wptr_o         (wptr),
    .wfull_o        (wfull),
    .walmost_full_o (walmost_full),
    .wlevel_o       (wlevel),
    .woverflow_o    (woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 32'd0);
    chk({tag, ".wptr"}, 32'(wptr), 32'd0);
    chk({tag, ".wfull"}, 32'(wfull), 32'd0);
    chk({tag, ".walmost"}, 32'(walmost_full), 32'd0);
    chk({tag, ".wlevel"}, 32'(wlevel), 32'd0);
    chk({tag, ".wovf"}, 32'(woverflow), 32'd0);
  endtask

  initial begin
    logic [4:0] d1, d2, b, g;

    // Reset held with write requests pending
    wrst_n   = 1'b0;
    winc     = 1'b1;
    wq2_rptr = 5'd0;
    wovf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all_zero($sformatf("rst%0d", i));
    end
    wrst_n = 1'b1;
    winc   = 1'b0;
    step();
    chk_all_zero("idle");

    // Fill 16 back-to-back writes
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      step();
      chk($sformatf("fill%0d.wlevel", i), 32'(wlevel), 32'(i));
      chk($sformatf("fill%0d.walmost", i), 32'(walmost_full), 32'(i >= 12));
      chk($sformatf("fill%0d.wfull", i), 32'(wfull), 32'(i == 16));
      chk($sformatf("fill%0d.waddr", i), 32'(waddr), 32'(i % 16));
    end
    winc = 1'b0;
    chk("fill.wptr", 32'(wptr), 32'h18);

    // Overflow while full
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("ovf.set", 32'(woverflow), 32'd1);
    chk("ovf.waddr", 32'(waddr), 32'd0);
    chk("ovf.wptr", 32'(wptr), 32'h18);
    chk("ovf.wlevel", 32'(wlevel), 32'd16);
    chk("ovf.wfull", 32'(wfull), 32'd1);
    winc     = 1'b1;
    wovf_clr = 1'b1;
    step();
    chk("ovf.set_wins", 32'(woverflow), 32'd1);
    chk("ovf.wptr2", 32'(wptr), 32'h18);
    winc = 1'b0;
    step();
    chk("ovf.clr", 32'(woverflow), 32'd0);
    wovf_clr = 1'b0;

    // Drain release
    wq2_rptr = 5'b00110;
    step();
    chk("drain4.wfull", 32'(wfull), 32'd0);
    chk("drain4.wlevel", 32'(wlevel), 32'd12);
    chk("drain4.walmost", 32'(walmost_full), 32'd1);
    wq2_rptr = 5'b00111;
    step();
    chk("drain5.wlevel", 32'(wlevel), 32'd11);
    chk("drain5.walmost", 32'(walmost_full), 32'd0);

    // Wrap: read pointer follows the write pointer two cycles behind
    wq2_rptr = 5'b11000;
    step();
    chk("wrap0.wlevel", 32'(wlevel), 32'd0);
    d1 = 5'b11000;
    d2 = 5'b11000;
    for (int k = 1; k <= 40; k++) begin
      wq2_rptr = d2;
      winc     = 1'b1;
      step();
      b = 5'((16 + k) % 32);
      g = b ^ (b >> 1);
      chk($sformatf("wrap%0d.waddr", k), 32'(waddr), 32'(k % 16));
      chk($sformatf("wrap%0d.wptr", k), 32'(wptr), 32'(g));
      chk($sformatf("wrap%0d.wfull", k), 32'(wfull), 32'd0);
      chk($sformatf("wrap%0d.wlevel", k), 32'(wlevel), (k == 1) ? 32'd1 : 32'd2);
      d2 = d1;
      d1 = wptr;
    end
    winc = 1'b0;

    // Mid-operation reset at level 9 (write count now 24)
    wq2_rptr = 5'b10100;
    step();
    chk("pre.wlevel", 32'(wlevel), 32'd0);
    winc = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("pre.wlevel9", 32'(wlevel), 32'd9);
    wrst_n = 1'b0;
    step();
    chk_all_zero("midrst");
    wrst_n   = 1'b1;
    wq2_rptr = 5'd0;
    step();
    chk("post.waddr", 32'(waddr), 32'd1);
    chk("post.wptr", 32'(wptr), 32'd1);
    chk("post.wlevel", 32'(wlevel), 32'd1);
    winc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-domain pointer and full-flag controller for the async FIFO, the write-side counterpart to the read-pointer/empty logic. Maintains the binary write address and Gray-coded write pointer exported to the read domain, and compares against the read pointer synchronized into `wclk` to produce `wfull`. Adds a registered occupancy level, an almost-full flag and a sticky overflow flag for upstream flow control and debug.

## Interface
- `ASIZE`, 4, address bits; FIFO depth = 2^ASIZE; legal range ASIZE >= 2.
- `AFULL_THRESH`, 12, occupancy at or above which `walmost_full` asserts; legal range 1..2^ASIZE.

- `wclk`  in  1  write clock; all logic on the rising edge.
- `wrst_n`  in  1  reset, synchronous, active-low.
- `winc`  in  1  write request for this cycle.
- `wq2_rptr`  in  ASIZE+1  Gray read pointer, already two-flop synchronized into `wclk`.
- `wovf_clr`  in  1  clears `woverflow`.
- `waddr`  out  ASIZE  RAM write address; equals `wbin[ASIZE-1:0]`.
- `wptr`  out  ASIZE+1  registered Gray write pointer, sent to the read-domain synchronizer.
- `wfull`  out  1  registered full flag.
- `walmost_full`  out  1  registered, set when level >= AFULL_THRESH.
- `wlevel`  out  ASIZE+1  registered occupancy, 0..2^ASIZE.
- `woverflow`  out  1  sticky; set when a write is attempted while full.

## Operation
- Internal state: `wbin` (ASIZE+1 bits, binary write count) and registers for `wptr`, `wfull`, `walmost_full`, `wlevel`, `woverflow`.
- Accept: `wen = winc & ~wfull`. `wbinnext = wbin + wen`, mod 2^(ASIZE+1). `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- Full: `wfull_val = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]})`.
- Read pointer decode: `rbin_s[ASIZE] = wq2_rptr[ASIZE]`; `rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i]` for i down to 0. This is combinational.
- Level: `wlevel_val = wbinnext - rbin_s`, mod 2^(ASIZE+1). The result is always <= 2^ASIZE, and it equals 2^ASIZE exactly when `wfull_val` is set.
- `walmost_full_val = (wlevel_val >= AFULL_THRESH)`.
- Overflow: `winc & wfull` sets `woverflow` on the next edge. The write is dropped, and `wbin`, `wptr` and `waddr` stay unchanged.
- `wovf_clr` clears `woverflow` on the next edge. If set and clear occur in the same cycle, set wins.
- Pessimism: the synchronized read pointer lags by 2 or more `wclk` cycles. As a result, `wlevel`, `walmost_full` and `wfull` may over-report occupancy and never under-report it. Deassertion after a read occurs 2-3 `wclk` cycles after the read-side pointer update.
- Reset (`wrst_n == 0` at an edge): `wbin`, `wptr`, `wlevel` = 0; `wfull`, `walmost_full`, `woverflow` = 0. Reset overrides all other inputs, and a write pending at that edge is discarded.
- Reset mid-operation returns the block to the empty state. The read domain must be reset coherently; the block does not check this.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- A write accepted at edge N (`winc=1`, `wfull=0`) has the following effects:
  - data is written at the `waddr` value present before edge N;
  - `waddr`/`wptr` advance at edge N;
  - `wfull`/`wlevel`/`walmost_full` reflect the write at edge N, with no bubble.
- The write that fills the last slot asserts `wfull` on the same edge it commits. A `winc` in the following cycle is dropped and flagged.
- Wrap-around: `wbin` rolls over from 2^(ASIZE+1)-1 to 0. The Gray MSB toggles every 2^ASIZE writes. Full/level remain correct across the wrap.
- A simultaneous remote read and local write in one cycle is seen as a level change of +1 now. The read is reflected when `wq2_rptr` updates.

## Test plan
- Reset, then hold `wrst_n=0` with `winc=1` for 3 cycles. Required: `waddr=0`, `wptr=0`, `wfull=0`, `wlevel=0`, `woverflow=0` throughout.
- Fill with `wq2_rptr=0`, ASIZE=4, 16 back-to-back writes.
  - `wlevel` steps 1..16.
  - `walmost_full` rises on the edge of the 12th write.
  - `wfull` rises on the edge of the 16th write.
  - Final `wptr=5'b11000`.
- Overflow while full: pulse `winc` once.
  - `woverflow=1` next cycle.
  - `waddr`, `wptr` and `wlevel=16` unchanged.
  - Then assert `winc` and `wovf_clr` together: `woverflow` stays 1.
  - Then `wovf_clr` alone: `woverflow` becomes 0.
- Drain release: from full, drive `wq2_rptr` to Gray(4)=`5'b00110`. Required, next edge: `wfull=0`, `wlevel=12`, `walmost_full=1`. Then drive Gray(5)=`5'b00111`: `wlevel=11`, `walmost_full=0`.
- Wrap: stream 40 writes with `wq2_rptr` tracking `wptr` delayed by 2 cycles. Required: `waddr` cycles 0..15, `wbin` wraps at 32, `wfull` never asserts, `wlevel` stays <= 3.
- Mid-operation reset at `wlevel=9`. Required, next edge: all outputs 0. The first write after release goes to `waddr=0`.
